// File: rtl/gate_test_sequencer.sv
// Sequences the four input vectors of a 2-input AND gate, waits a programmable dwell,
// samples the gate output and records per-vector mismatches.
module gate_test_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               gateOut,
  output logic               input1,
  output logic               input2,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [3:0]         failMask,
  output logic [2:0]         errCount
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         v_q, v_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwl_q, dwl_d;
  logic               in1_q, in1_d, in2_q, in2_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0]         mask_q, mask_d;
  logic [2:0]         err_q, err_d;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      dwl_q   <= '0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      dwl_q   <= dwl_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    dwl_d   = dwl_q;
    pass_d  = pass_q;
    mask_d  = mask_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = SETTLE;
          v_d     = '0;
          // A zero dwell is promoted to one so every vector settles at least a cycle.
          dwl_d   = (dwell == '0) ? DWELL_W'(1) : dwell;
          cnt_d   = dwl_d;
          mask_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
          if (cnt_q <= DWELL_W'(1)) state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // Inputs currently driven are v_q, so the reference is v_q[0] & v_q[1].
          if (gateOut != (v_q[0] & v_q[1])) begin
            mask_d[v_q] = 1'b1;
            err_d       = err_q + 3'd1;
          end
          if (v_q == 2'd3) begin
            state_d = DONE;
            pass_d  = (err_d == 3'd0);
          end else begin
            state_d = SETTLE;
            v_d     = v_q + 2'd1;
            cnt_d   = dwl_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    in1_d  = busy_d & v_d[0];
    in2_d  = busy_d & v_d[1];
  end

  assign input1   = in1_q;
  assign input2   = in2_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign failMask = mask_q;
  assign errCount = err_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: table of full runs against good/faulty gate models,
// plus abort, mid-run reset and start+abort sequences.
module tb_gate_test_sequencer;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] dwell = '0;
  logic       gateOut;
  logic       input1, input2, busy, done, pass;
  logic [3:0] failMask;
  logic [2:0] errCount;

  int mode = 0;   // 0: AND, 1: stuck-at-1, 2: OR
  int cyc  = 0;
  int n_chk = 0, n_fail = 0, n_done = 0;

  typedef struct {
    int         mode;
    int         dwell;
    logic [3:0] mask;
    logic [2:0] err;
    logic       pss;
    bit         ign;
  } vec_t;

  typedef struct {
    logic [3:0] mask;
    logic [2:0] err;
    logic       pss;
    int         cyc;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign gateOut = (mode == 0) ? (input1 & input2) :
                   (mode == 1) ? 1'b1 : (input1 | input2);

  gate_test_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rstN(rstN), .start(start), .abort(abort), .dwell(dwell),
    .gateOut(gateOut), .input1(input1), .input2(input2), .busy(busy),
    .done(done), .pass(pass), .failMask(failMask), .errCount(errCount)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      chk("done_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        sb_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("failMask", failMask, e.mask);
        chk("errCount", errCount, e.err);
        chk("pass", pass, e.pss);
      end
    end
  end

  task automatic chk_idle_zero(input string nm);
    chk(nm, {busy, done, input1, input2}, 4'b0000);
  endtask

  task automatic start_run(input int dw, output int k);
    @(negedge clk);
    dwell = dw[7:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
  endtask

  task automatic run_vec(input vec_t r);
    int k, d, n0;
    sb_t e;
    d  = (r.dwell == 0) ? 1 : r.dwell;
    mode = r.mode;
    n0 = n_done;
    start_run(r.dwell, k);
    e.mask = r.mask; e.err = r.err; e.pss = r.pss; e.cyc = k + 4 * (d + 1);
    sb.push_back(e);
    for (int t = 0; t < 4 * (d + 1); t++) begin
      int v;
      v = t / (d + 1);
      chk("vec_drive", {busy, input1, input2}, {1'b1, v[0], v[1]});
      start = r.ign && (t == 4);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_inputs_low", {busy, input1, input2}, 3'b000);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("result_hold", {pass, failMask, errCount}, {r.pss, r.mask, r.err});
    chk("done_count", n_done - n0, 1);
  endtask

  initial begin
    int k, n0;
    tbl[0] = '{mode: 0, dwell: 3,   mask: 4'b0000, err: 3'd0, pss: 1'b1, ign: 1'b0};
    tbl[1] = '{mode: 1, dwell: 0,   mask: 4'b0111, err: 3'd3, pss: 1'b0, ign: 1'b0};
    tbl[2] = '{mode: 2, dwell: 2,   mask: 4'b0110, err: 3'd2, pss: 1'b0, ign: 1'b1};
    tbl[3] = '{mode: 0, dwell: 1,   mask: 4'b0000, err: 3'd0, pss: 1'b1, ign: 1'b0};
    tbl[4] = '{mode: 2, dwell: 0,   mask: 4'b0110, err: 3'd2, pss: 1'b0, ign: 1'b0};
    tbl[5] = '{mode: 0, dwell: 255, mask: 4'b0000, err: 3'd0, pss: 1'b1, ign: 1'b0};

    // Reset state before any clock edge, then 3 cycles held.
    #1;
    chk("reset_async", {busy, done, pass, input1, input2, failMask, errCount}, 12'h0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {busy, done, pass, input1, input2, failMask, errCount}, 12'h0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Abort during vector-2 SETTLE.
    mode = 0;
    n0 = n_done;
    start_run(3, k);
    repeat (9) @(negedge clk);
    chk("pre_abort_vec2", {busy, input1, input2}, 3'b101);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle_zero("abort_idle");
    chk("abort_pass", pass, 1'b0);
    chk("abort_partial", {failMask, errCount}, 7'h0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", n_done - n0, 0);
    run_vec(tbl[0]);

    // Reset during vector-1 SAMPLE with partial results recorded.
    mode = 1;
    n0 = n_done;
    start_run(3, k);
    repeat (7) @(negedge clk);
    chk("pre_reset_partial", {busy, input1, input2, failMask, errCount}, {3'b110, 4'b0001, 3'd1});
    rstN = 1'b0;
    #1;
    chk("reset_midrun_async", {busy, done, pass, input1, input2, failMask, errCount}, 12'h0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (20) @(negedge clk);
    chk_idle_zero("reset_midrun_idle");
    chk("reset_no_done", n_done - n0, 0);

    // start and abort together in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("start_abort_busy", busy, 1'b0);
      @(negedge clk);
    end

    run_vec(tbl[3]);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell-count input.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rstN  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request a full test run; sampled only in IDLE.
REQ-006 Port: abort  input  1  terminate the run in progress.
REQ-007 Port: dwell  input  DWELL_W  settle cycles per vector; latched on start acceptance.
REQ-008 Port: gateOut  input  1  output of the 2-input AND gate under test (andGate).
REQ-009 Port: input1  output  1  drives gate input1.
REQ-010 Port: input2  output  1  drives gate input2.
REQ-011 Port: busy  output  1  high in SETTLE and SAMPLE.
REQ-012 Port: done  output  1  one-cycle pulse on completion of a full run.
REQ-013 Port: pass  output  1  high when the last completed run had zero mismatches.
REQ-014 Port: failMask  output  4  bit v set when vector v mismatched.
REQ-015 Port: errCount  output  3  number of mismatching vectors, 0-4.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE; all outputs SHALL be registered.
REQ-017 Start acceptance: start=1 and abort=0 in IDLE at edge k -> SETTLE; vector index v=0; D=max(dwell,1) latched; failMask, errCount and pass cleared.
REQ-018 Vector order: v=0..3; input1=v[0], input2=v[1], giving (0,0),(1,0),(0,1),(1,1).
REQ-019 input1/input2 SHALL hold the vector value through SETTLE and SAMPLE; they SHALL be 0 in IDLE and DONE.
REQ-020 SETTLE SHALL last exactly D cycles, counted by a DWELL_W-bit down-counter; dwell=0 SHALL behave as dwell=1.
REQ-021 SAMPLE SHALL last one cycle; expected = input1 & input2; on gateOut != expected, set failMask[v] and increment errCount.
REQ-022 After SAMPLE: v<3 -> v+1 and SETTLE; v=3 -> DONE.
REQ-023 DONE SHALL last one cycle with done=1, pass=(errCount==0), and then go to IDLE.
REQ-024 Latency: a start accepted at edge k SHALL put DONE at edge k+4*(D+1).
REQ-025 pass, failMask and errCount SHALL hold from DONE until the next accepted start.
REQ-026 start SHALL be ignored in SETTLE, SAMPLE and DONE.
REQ-027 abort=1 in SETTLE or SAMPLE -> IDLE at the next edge; input1=input2=0; no done pulse; pass=0; failMask and errCount keep partial values.
REQ-028 start and abort both high in IDLE -> remain in IDLE (abort wins).
REQ-029 A mismatch sampled in the same cycle as abort SHALL NOT be recorded.

Reset
REQ-030 rstN=0 SHALL immediately force IDLE, v=0, counter=0, and input1, input2, busy, done, pass, failMask, errCount all 0, without waiting for a clock edge.
REQ-031 Reset deassertion SHALL take effect at the first rising edge with rstN=1; the block stays in IDLE until start.
REQ-032 rstN=0 mid-run SHALL abandon the run with no done pulse.

Verification
REQ-033 Reset: rstN=0 for 3 cycles at any state -> all outputs 0 immediately; IDLE after release.
REQ-034 Good AND gate, dwell=3, start pulse at edge k -> (0,0),(1,0),(0,1),(1,1) each held 4 cycles; done at edge k+16; pass=1, failMask=0000, errCount=0.
REQ-035 Stuck-at-1 gate model, dwell=0 -> 2 cycles per vector; done at edge k+8; failMask=0111, errCount=3, pass=0.
REQ-036 OR gate substituted, dwell=2 -> failMask=0110, errCount=2, pass=0; done at k+12; start asserted at k+5 ignored.
REQ-037 Good gate, dwell=3, abort in vector-2 SETTLE -> IDLE next edge; input1=input2=0; no done; pass=0; a following start runs cleanly to pass=1.
REQ-038 Corner cases: rstN low during vector-1 SAMPLE -> outputs 0 asynchronously; start+abort together in IDLE -> busy stays 0; dwell=255 -> done at k+1024.
